video_planar: RTL and testbench

- Parametrised planar video serialiser for the Lynx video path; successor to the fixed 3-plane, 8-pixel shifter.
- Fetches one byte per colour plane from video RAM in fixed slots of a character period, transfers all planes together into output shift registers, and emits one multi-plane pixel per pixel-clock enable.
- Adds a plane-enable mask, a border colour outside the display window, a registered display-active flag and a generalised bank-select output.

---
 rtl/video_planar.sv | 91 +++++++++
 tb/tb_video_planar.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/video_planar.sv
// Planar video serialiser: fetches one byte per colour plane into latches during
// a character period, transfers them into shift registers and emits one pixel per ce.
module video_planar #(
  parameter int PLANES = 3,
  parameter int SLOTS  = 8,
  parameter int BW     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hSync,
  input  logic              ce,
  input  logic              de,
  input  logic              altg,
  input  logic [PLANES-1:0] mask,
  input  logic [PLANES-1:0] border,
  input  logic [SLOTS-1:0]  d,
  output logic [PLANES-1:0] pixel,
  output logic              active,
  output logic [BW-1:0]     bank
);

  localparam int SW = $clog2(SLOTS);

  logic [SW-1:0]                   slot_q, slot_d;
  logic [PLANES-1:0][SLOTS-1:0]    latch_q, latch_d;
  logic [PLANES-1:0][SLOTS-1:0]    shift_q, shift_d;
  logic                            active_q, active_d;
  logic [SW-1:0]                   pair;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_q   <= '0;
      latch_q  <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      latch_q  <= latch_d;
      shift_q  <= shift_d;
      active_q <= active_d;
    end
  end

  // hSync clears the slot counter even when ce is low; SLOTS is a power of two so it wraps freely.
  always_comb begin
    slot_d = slot_q;
    if (hSync)   slot_d = '0;
    else if (ce) slot_d = slot_q + 1'b1;
  end

  always_comb begin
    latch_d = latch_q;
    for (int p = 0; p < PLANES; p++) begin
      if (ce && de && (slot_q == SW'(2 * p + 1))) latch_d[p] = d;
    end
  end

  // Without de at the transfer slot the registers keep shifting out zeros and
  // active drops, so latched data from a partial period is never shown.
  always_comb begin
    shift_d  = shift_q;
    active_d = active_q;
    if (ce) begin
      if ((slot_q == SW'(SLOTS - 1)) && de) begin
        shift_d  = latch_q;
        active_d = 1'b1;
      end else begin
        for (int p = 0; p < PLANES; p++) shift_d[p] = {shift_q[p][SLOTS-2:0], 1'b0};
        if (slot_q == SW'(SLOTS - 1)) active_d = 1'b0;
      end
    end
  end

  always_comb begin
    pixel = '0;
    for (int p = 0; p < PLANES; p++) begin
      pixel[p] = active_q ? (shift_q[p][SLOTS-1] & mask[p]) : border[p];
    end
  end

  assign active = active_q;

  // Each plane owns a slot pair; the last plane's pair can be redirected to the alternate green bank.
  always_comb begin
    pair = slot_q >> 1;
    bank = BW'(PLANES);
    if (int'(pair) < PLANES - 1)       bank = BW'(pair);
    else if (int'(pair) == PLANES - 1) bank = altg ? BW'(PLANES - 1) : BW'(PLANES);
  end

endmodule

// File: tb/tb_video_planar.sv
// Directed bench for video_planar with default parameters: table of full-period
// vectors plus hand sequences for reset, bank sweep, hSync and async reset.
module tb_video_planar;

  logic       clock = 1'b0;
  logic       reset;
  logic       hSync;
  logic       ce;
  logic       de;
  logic       altg;
  logic [2:0] mask;
  logic [2:0] border;
  logic [7:0] d;
  logic [2:0] pixel;
  logic       active;
  logic [1:0] bank;

  int errors = 0;
  int checks = 0;

  video_planar dut (
    .clock  (clock),
    .reset  (reset),
    .hSync  (hSync),
    .ce     (ce),
    .de     (de),
    .altg   (altg),
    .mask   (mask),
    .border (border),
    .d      (d),
    .pixel  (pixel),
    .active (active),
    .bank   (bank)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]      d0, d1, d2;
    logic [2:0]      mask;
    logic [2:0]      border;
    logic            de_xfer;
    logic            exp_active;
    logic [7:0][2:0] exp_pix;   // element 7 = first pixel shown
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs after a falling edge, take one rising edge, return at the next falling edge.
  task automatic step(input logic ce_v, input logic de_v, input logic [7:0] d_v, input logic hs_v);
    ce = ce_v; de = de_v; d = d_v; hSync = hs_v;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic align();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    hSync = 1'b0;
  endtask

  task automatic load_period(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic de_x);
    for (int s = 0; s < 8; s++) begin
      logic [7:0] dv;
      dv = (s == 1) ? d0 : (s == 3) ? d1 : (s == 5) ? d2 : 8'h00;
      step(1'b1, (s == 7) ? de_x : 1'b1, dv, 1'b0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    mask   = v.mask;
    border = v.border;
    align();
    load_period(v.d0, v.d1, v.d2, v.de_xfer);
    for (int s = 0; s < 8; s++) begin
      chk($sformatf("vec%0d pixel s%0d", idx, s), {5'd0, pixel}, {5'd0, v.exp_pix[7-s]});
      chk($sformatf("vec%0d active s%0d", idx, s), {7'd0, active}, {7'd0, v.exp_active});
      step(1'b1, 1'b0, 8'h00, 1'b0);
    end
  endtask

  vec_t vecs [4];
  logic [1:0] exp_bank0 [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
  logic [1:0] exp_bank1 [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

  initial begin
    vecs[0] = '{d0: 8'hA5, d1: 8'h0F, d2: 8'hF0, mask: 3'b111, border: 3'b000,
                de_xfer: 1'b1, exp_active: 1'b1,
                exp_pix: {3'b101, 3'b100, 3'b101, 3'b100, 3'b010, 3'b011, 3'b010, 3'b011}};
    vecs[1] = '{d0: 8'hA5, d1: 8'h0F, d2: 8'hF0, mask: 3'b010, border: 3'b111,
                de_xfer: 1'b1, exp_active: 1'b1,
                exp_pix: {3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010}};
    vecs[2] = '{d0: 8'hFF, d1: 8'h00, d2: 8'h81, mask: 3'b101, border: 3'b010,
                de_xfer: 1'b1, exp_active: 1'b1,
                exp_pix: {3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b101}};
    vecs[3] = '{d0: 8'hFF, d1: 8'hFF, d2: 8'hFF, mask: 3'b111, border: 3'b110,
                de_xfer: 1'b0, exp_active: 1'b0,
                exp_pix: {8{3'b110}}};

    reset = 1'b0; hSync = 1'b0; ce = 1'b0; de = 1'b0; altg = 1'b0;
    mask = 3'b111; border = 3'b000; d = 8'h00;

    // Reset state and release with ce low
    @(negedge clock);
    chk("reset pixel", {5'd0, pixel}, 8'h00);
    chk("reset active", {7'd0, active}, 8'h00);
    chk("reset bank", {6'd0, bank}, 8'h00);
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("post-reset active", {7'd0, active}, 8'h00);
    chk("post-reset bank", {6'd0, bank}, 8'h00);
    border = 3'b101;
    #1;
    chk("border follow", {5'd0, pixel}, 8'h05);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Bank sweep, altg low then high
    for (int a = 0; a < 2; a++) begin
      altg = a[0];
      align();
      for (int s = 0; s < 8; s++) begin
        chk($sformatf("bank altg%0d s%0d", a, s), {6'd0, bank},
            {6'd0, (a == 0) ? exp_bank0[s] : exp_bank1[s]});
        step(1'b1, 1'b0, 8'h00, 1'b0);
      end
    end

    // hSync at slot 4 with ce low
    altg = 1'b0;
    align();
    for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("hsync pre slot4", {6'd0, bank}, 8'h03);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("hsync slot0", {6'd0, bank}, 8'h00);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("hsync slot1", {6'd0, bank}, 8'h00);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("hsync slot2", {6'd0, bank}, 8'h01);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ce low holds slot", {6'd0, bank}, 8'h01);

    // Asynchronous reset in the middle of a displayed period
    mask = 3'b111; border = 3'b011;
    align();
    load_period(8'hA5, 8'h0F, 8'hF0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("midshift active", {7'd0, active}, 8'h01);
    chk("midshift pixel", {5'd0, pixel}, 8'h05);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset pixel", {5'd0, pixel}, 8'h03);
    chk("async reset active", {7'd0, active}, 8'h00);
    chk("async reset bank", {6'd0, bank}, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("after reset active", {7'd0, active}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
